// File: rtl/ysyx_22050598_clint_if.sv
// Request/response bus between the data-side interconnect and the CLINT.
// One request can be outstanding at a time.
interface ysyx_22050598_clint_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_22050598_clint.sv
// Core-local interruptor: msip/mtimecmp/mtime registers, the free-running
// timer and the machine timer/software interrupt levels for the trap unit.
module ysyx_22050598_clint #(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22050598_clint_if.slave       bus,
  output logic                       irq_mtip_o,
  output logic                       irq_msip_o,
  output logic [63:0]                time_o
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  typedef enum logic {IDLE, RESP} state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   mtime_q, mtimecmp_q;
  logic              msip_q, mtip_q;
  logic [PW-1:0]     presc_q;

  logic              accept, tick;
  logic              base_hit, sel_msip, sel_cmp, sel_time, mapped;
  logic [15:0]       offset;
  logic [XLEN-1:0]   rd_data;

  // Byte-lane merge of a write into an existing register value.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] new_v,
                                                  input logic [NB-1:0]   strb);
    logic [XLEN-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(NB); i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign irq_mtip_o    = mtip_q;
  assign irq_msip_o    = msip_q;
  assign time_o        = mtime_q;

  // Address decode; misaligned or foreign addresses fall out as unmapped.
  always_comb begin
    offset   = bus.req_addr[15:0];
    base_hit = (bus.req_addr[63:16] == BASE[63:16]) && (bus.req_addr[2:0] == 3'b000);
    sel_msip = base_hit && (offset == OFF_MSIP);
    sel_cmp  = base_hit && (offset == OFF_MTIMECMP);
    sel_time = base_hit && (offset == OFF_MTIME);
    mapped   = sel_msip | sel_cmp | sel_time;
    rd_data  = '0;
    if (sel_msip)      rd_data = {{(XLEN-1){1'b0}}, msip_q};
    else if (sel_cmp)  rd_data = mtimecmp_q;
    else if (sel_time) rd_data = mtime_q;
  end

  assign accept = bus.req_valid & req_ready_q;
  assign tick   = (presc_q == PW'(TICK_DIV - 1));

  // Handshake FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
    end
  end

  // Handshake FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response payload is captured on the accept edge and held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_rdata_q <= bus.req_wen ? '0 : rd_data;
      rsp_err_q   <= ~mapped;
    end
  end

  // Timer: a bus write to mtime overrides the tick increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (accept && bus.req_wen && sel_time)
        mtime_q <= merge_bytes(mtime_q, bus.req_wdata, bus.req_wstrb);
      else if (tick)
        mtime_q <= mtime_q + XLEN'(1);
    end
  end

  // Compare/software-interrupt registers and the registered timer level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      mtip_q <= (mtime_q >= mtimecmp_q);
      if (accept && bus.req_wen && sel_cmp)
        mtimecmp_q <= merge_bytes(mtimecmp_q, bus.req_wdata, bus.req_wstrb);
      if (accept && bus.req_wen && sel_msip && bus.req_wstrb[0])
        msip_q <= bus.req_wdata[0];
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_clint.sv
// Bench for the CLINT: a register-level reference model tracks the TICK_DIV=1
// instance; a second TICK_DIV=4 instance checks prescaling and async reset.
module tb_ysyx_22050598_clint;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

  logic clk, rst1, rst4;
  logic        mtip1, msip1, mtip4, msip4;
  logic [63:0] time1, time4;
  int tests, fails;

  ysyx_22050598_clint_if bus1();
  ysyx_22050598_clint_if bus4();

  ysyx_22050598_clint #(.BASE(BASE), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .irq_mtip_o(mtip1), .irq_msip_o(msip1), .time_o(time1));
  ysyx_22050598_clint #(.BASE(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4), .irq_mtip_o(mtip4), .irq_msip_o(msip4), .time_o(time4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents of the TICK_DIV=1 instance.
  logic [63:0] m_time, m_cmp, exp_rdata;
  logic        m_msip, m_mtip, exp_err;
  logic [63:0] nt, rd;
  logic        ok;
  logic [15:0] off;

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      m_time <= 64'd0; m_cmp <= '1; m_msip <= 1'b0; m_mtip <= 1'b0;
      exp_rdata <= 64'd0; exp_err <= 1'b0;
    end else begin
      nt = m_time + 64'd1;
      m_mtip <= (m_time >= m_cmp);
      if (bus1.req_valid) begin
        off = bus1.req_addr[15:0];
        ok  = (bus1.req_addr[63:16] == BASE[63:16]) && (bus1.req_addr[2:0] == 3'd0) &&
              (off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8);
        rd  = !ok ? 64'd0 : (off == 16'h0000) ? {63'd0, m_msip} : (off == 16'h4000) ? m_cmp : m_time;
        exp_err   <= !ok;
        exp_rdata <= bus1.req_wen ? 64'd0 : rd;
        if (bus1.req_wen && ok) begin
          if (off == 16'h0000 && bus1.req_wstrb[0]) m_msip <= bus1.req_wdata[0];
          if (off == 16'h4000) m_cmp <= merge(m_cmp, bus1.req_wdata, bus1.req_wstrb);
          if (off == 16'hBFF8) nt = merge(m_time, bus1.req_wdata, bus1.req_wstrb);
        end
      end
      m_time <= nt;
    end
  end

  // One bus transaction on bus1; rsp_ready is withheld for `hold` cycles.
  task automatic xfer(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] strb, input int hold,
                      output logic rdy, output logic vld, output logic [63:0] rdata,
                      output logic err, output logic stable,
                      output logic [63:0] t_dut, output logic [63:0] t_mod);
    @(negedge clk);
    rdy = bus1.req_ready;
    bus1.req_valid = 1'b1; bus1.req_wen = wen; bus1.req_addr = addr;
    bus1.req_wdata = wdata; bus1.req_wstrb = strb; bus1.rsp_ready = (hold == 0);
    @(negedge clk);
    bus1.req_valid = 1'b0; bus1.req_wen = 1'b0;
    vld = bus1.rsp_valid; rdata = bus1.rsp_rdata; err = bus1.rsp_err;
    t_dut = time1; t_mod = m_time;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== rdata || bus1.rsp_err !== err ||
          bus1.req_ready !== 1'b0) stable = 1'b0;
    end
    bus1.rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  logic        r_rdy, r_vld, r_err, r_stb;
  logic [63:0] r_data, r_td, r_tm;

  task automatic test_reset;
    rst1 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests++; if (time1 !== 64'd0 || mtip1 !== 1'b0 || msip1 !== 1'b0) begin fails++;
      $display("FAIL reset_irq_time: time=%0h mtip=%b msip=%b, want 0/0/0", time1, mtip1, msip1); end
    tests++; if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== 64'd0 || bus1.rsp_err !== 1'b0) begin fails++;
      $display("FAIL reset_bus: ready=%b valid=%b rdata=%0h err=%b, want 1/0/0/0",
               bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err); end
    @(negedge clk); rst1 = 1'b1;
    repeat (10) @(negedge clk);
    tests++; if (time1 !== 64'd10 || mtip1 !== 1'b0 || msip1 !== 1'b0) begin fails++;
      $display("FAIL free_run_10: time=%0d mtip=%b msip=%b, want 10/0/0", time1, mtip1, msip1); end
  endtask

  task automatic test_mtip;
    xfer(1'b1, BASE + 64'h4000, 64'd20, 8'hFF, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_rdy !== 1'b1 || r_vld !== 1'b1 || r_err !== 1'b0 || r_data !== 64'd0) begin fails++;
      $display("FAIL cmp_write_rsp: rdy=%b vld=%b err=%b rdata=%0h, want 1/1/0/0", r_rdy, r_vld, r_err, r_data); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      tests++; if (mtip1 !== m_mtip || time1 !== m_time) begin fails++;
        $display("FAIL mtip_track: mtip=%b time=%0d, want %b/%0d", mtip1, time1, m_mtip, m_time); end
    end
    tests++; if (mtip1 !== 1'b1) begin fails++; $display("FAIL mtip_set: got %b want 1", mtip1); end
    xfer(1'b1, BASE + 64'h4000, 64'd100, 8'hFF, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    @(negedge clk);
    tests++; if (mtip1 !== 1'b0) begin fails++; $display("FAIL mtip_clear: got %b want 0", mtip1); end
  endtask

  task automatic test_msip;
    xfer(1'b1, BASE, 64'h0000_0000_FFFF_FFFF, 8'h0F, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    @(negedge clk);
    tests++; if (msip1 !== 1'b1) begin fails++; $display("FAIL msip_set: got %b want 1", msip1); end
    xfer(1'b0, BASE, 64'd0, 8'h00, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_vld !== 1'b1 || r_data !== 64'd1 || r_err !== 1'b0) begin fails++;
      $display("FAIL msip_read: vld=%b rdata=%0h err=%b, want 1/1/0", r_vld, r_data, r_err); end
    xfer(1'b1, BASE, 64'd0, 8'h01, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    @(negedge clk);
    tests++; if (msip1 !== 1'b0) begin fails++; $display("FAIL msip_clear: got %b want 0", msip1); end
  endtask

  task automatic test_mtime_wrap;
    xfer(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_td !== 64'hFFFF_FFFF_FFFF_FFFE) begin fails++;
      $display("FAIL mtime_collide_full: time=%0h want fffffffffffffffe", r_td); end
    @(negedge clk);
    tests++; if (time1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL wrap_max: time=%0h want ffffffffffffffff", time1); end
    @(negedge clk);
    tests++; if (time1 !== 64'd0) begin fails++; $display("FAIL wrap_zero: time=%0h want 0", time1); end
    @(negedge clk);
    tests++; if (time1 !== 64'd1) begin fails++; $display("FAIL wrap_one: time=%0h want 1", time1); end
    xfer(1'b1, BASE + 64'hBFF8, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_td !== r_tm) begin fails++; $display("FAIL mtime_collide_partial: time=%0h want %0h", r_td, r_tm); end
    xfer(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_data !== exp_rdata || r_err !== 1'b0) begin fails++;
      $display("FAIL mtime_read: rdata=%0h err=%b, want %0h/0", r_data, r_err, exp_rdata); end
  endtask

  task automatic test_unmapped;
    xfer(1'b0, BASE + 64'h1000, 64'd0, 8'h00, 5, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_vld !== 1'b1 || r_err !== 1'b1 || r_data !== 64'd0 || r_stb !== 1'b1) begin fails++;
      $display("FAIL unmapped_read: vld=%b err=%b rdata=%0h stable=%b, want 1/1/0/1", r_vld, r_err, r_data, r_stb); end
    xfer(1'b1, BASE + 64'h4004, '1, 8'hFF, 5, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_vld !== 1'b1 || r_err !== 1'b1 || r_data !== 64'd0 || r_stb !== 1'b1) begin fails++;
      $display("FAIL misaligned_write: vld=%b err=%b rdata=%0h stable=%b, want 1/1/0/1", r_vld, r_err, r_data, r_stb); end
    xfer(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 0, r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
    tests++; if (r_data !== 64'd100 || r_err !== 1'b0) begin fails++;
      $display("FAIL cmp_untouched: rdata=%0h err=%b, want 100/0", r_data, r_err); end
  endtask

  function automatic logic [63:0] pick_addr(input int unsigned k);
    case (k)
      0: return BASE;
      1, 6: return BASE + 64'h4000;
      2: return BASE + 64'hBFF8;
      3: return BASE + 64'h1000;
      4: return BASE + 64'h0004;
      default: return BASE + 64'h1_4000;
    endcase
  endfunction

  task automatic test_random;
    logic [63:0] a, d;
    logic        w;
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(negedge clk);
        tests++; if (mtip1 !== m_mtip || msip1 !== m_msip || time1 !== m_time) begin fails++;
          $display("FAIL rand_idle: mtip=%b msip=%b time=%0h, want %b/%b/%0h", mtip1, msip1, time1, m_mtip, m_msip, m_time); end
      end
      a = pick_addr($urandom_range(0, 6));
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      if (a == BASE + 64'h4000) d = m_time + 64'($urandom_range(0, 8));
      xfer(w, a, d, 8'($urandom), int'($urandom_range(0, 2)), r_rdy, r_vld, r_data, r_err, r_stb, r_td, r_tm);
      tests++; if (r_rdy !== 1'b1 || r_vld !== 1'b1 || r_stb !== 1'b1 || r_data !== exp_rdata ||
                   r_err !== exp_err || r_td !== r_tm) begin fails++;
        $display("FAIL rand_xfer: rdy=%b vld=%b stable=%b rdata=%0h err=%b time=%0h, want 1/1/1/%0h/%b/%0h",
                 r_rdy, r_vld, r_stb, r_data, r_err, r_td, exp_rdata, exp_err, r_tm); end
    end
  endtask

  task automatic test_div4_and_async_reset;
    int e;
    rst4 = 1'b0;
    @(negedge clk); rst4 = 1'b1; e = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk); e++;
      tests++; if (time4 !== 64'(e / 4)) begin fails++; $display("FAIL div4_time: edge %0d time=%0d want %0d", e, time4, e / 4); end
    end
    bus4.req_valid = 1'b1; bus4.req_wen = 1'b1; bus4.req_addr = BASE; bus4.req_wdata = 64'd1;
    bus4.req_wstrb = 8'h01; bus4.rsp_ready = 1'b1;
    @(negedge clk); e++;
    bus4.req_valid = 1'b0;
    tests++; if (msip4 !== 1'b1) begin fails++; $display("FAIL div4_msip: got %b want 1", msip4); end
    @(negedge clk); e++;
    bus4.req_valid = 1'b1; bus4.req_wen = 1'b0; bus4.req_addr = BASE + 64'hBFF8; bus4.rsp_ready = 1'b0;
    @(negedge clk); e++;
    bus4.req_valid = 1'b0;
    tests++; if (bus4.rsp_valid !== 1'b1 || bus4.rsp_rdata !== 64'((e - 1) / 4) || time4 !== 64'(e / 4)) begin fails++;
      $display("FAIL div4_read: valid=%b rdata=%0d time=%0d, want 1/%0d/%0d", bus4.rsp_valid, bus4.rsp_rdata, time4, (e - 1) / 4, e / 4); end
    #2 rst4 = 1'b0;
    #1;
    tests++; if (bus4.req_ready !== 1'b1 || bus4.rsp_valid !== 1'b0 || bus4.rsp_rdata !== 64'd0 || bus4.rsp_err !== 1'b0 ||
                 time4 !== 64'd0 || mtip4 !== 1'b0 || msip4 !== 1'b0) begin fails++;
      $display("FAIL async_reset: ready=%b valid=%b rdata=%0h err=%b time=%0h mtip=%b msip=%b, want 1/0/0/0/0/0/0",
               bus4.req_ready, bus4.rsp_valid, bus4.rsp_rdata, bus4.rsp_err, time4, mtip4, msip4); end
    @(negedge clk); rst4 = 1'b1; bus4.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++; if (bus4.rsp_valid !== 1'b0 || bus4.req_ready !== 1'b1) begin fails++;
        $display("FAIL no_rsp_after_reset: valid=%b ready=%b, want 0/1", bus4.rsp_valid, bus4.req_ready); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst1 = 1'b0; rst4 = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_wen = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.req_wstrb = '0; bus1.rsp_ready = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_wen = 1'b0; bus4.req_addr = '0; bus4.req_wdata = '0;
    bus4.req_wstrb = '0; bus4.rsp_ready = 1'b1;
    test_reset;
    test_mtip;
    test_msip;
    test_mtime_wrap;
    test_unmapped;
    test_random;
    test_div4_and_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
